// File: rtl/fpu_pkg.sv
// Shared FPU constants and types: IEEE-754 single layout, extended mantissa bit
// positions, canonical results and the operator tag encoding.
package fpu_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int MANT_W   = 28;
  localparam int EXP_W    = 10;

  // Extended mantissa: [27] carry, [26] hidden, [25:3] fraction, [2:0] G/R/S
  localparam int CARRY  = 27;
  localparam int HIDDEN = 26;
  localparam int G      = 2;
  localparam int R      = 1;
  localparam int S      = 0;

  localparam logic [31:0] POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF  = 32'hFF80_0000;
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] NEG_ZERO = 32'h8000_0000;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01
  } fpu_op_e;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } fpu_flags_t;

  function automatic logic [31:0] pack_sp(input logic sign, input logic [7:0] exp8,
                                          input logic [22:0] frac);
    return {sign, exp8, frac};
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; the count is taken from the MSB downward
// and equals W when the input is all zeros.
module fpu_lzc #(
  parameter int W  = 27,
  parameter int CW = 5
) (
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] count_o
);

  // Scanning upward lets the highest set bit make the final assignment.
  always_comb begin
    count_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data_i[i]) count_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_pack.sv
// FPU back end: normalize, round-to-nearest-even and pack an IEEE-754 single in a
// three-stage pipeline that stalls as a whole under consumer backpressure.
module fpu_pack
  import fpu_pkg::*;
#(
  parameter int MANT_W = 28,
  parameter int EXP_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exponent,
  input  logic [MANT_W-1:0] in_mantissa,
  input  logic [1:0]        in_operator,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [1:0]        out_operator,
  output logic              out_overflow,
  output logic              out_underflow,
  output logic              out_inexact
);

  localparam int XW = EXP_W + 1;
  localparam int NW = MANT_W - 1;
  localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
  localparam logic signed [XW-1:0] EXP_TOP = XW'(EXP_MAX);
  localparam logic signed [XW-1:0] EXP_LOW = '0;

  logic advance;
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  // ---------------- S1: normalize ----------------
  logic [4:0]           lzc;
  logic signed [XW-1:0] exp_ext;
  logic signed [XW-1:0] s1_exp_d;
  logic [NW-1:0]        s1_mant_d;
  logic                 s1_zero_d;

  fpu_lzc #(.W(NW), .CW(5)) u_lzc (
    .data_i (in_mantissa[NW-1:0]),
    .count_o(lzc)
  );

  assign exp_ext = {in_exponent[EXP_W-1], in_exponent};

  always_comb begin
    s1_zero_d = (in_mantissa == '0);
    s1_mant_d = in_mantissa[NW-1:0] << lzc;
    s1_exp_d  = exp_ext - $signed({{(XW-5){1'b0}}, lzc});
    if (in_mantissa[CARRY]) begin
      s1_mant_d = {in_mantissa[CARRY:G], in_mantissa[R] | in_mantissa[S]};
      s1_exp_d  = exp_ext + EXP_ONE;
    end
  end

  logic                 s1_valid_q, s1_sign_q, s1_zero_q;
  logic signed [XW-1:0] s1_exp_q;
  logic [NW-1:0]        s1_mant_q;
  logic [1:0]           s1_op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_mant_q  <= '0;
      s1_op_q    <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s1_sign_q  <= in_sign;
      s1_zero_q  <= s1_zero_d;
      s1_exp_q   <= s1_exp_d;
      s1_mant_q  <= s1_mant_d;
      s1_op_q    <= in_operator;
    end
  end

  // ---------------- S2: round to nearest even ----------------
  logic                 round_up;
  logic [24:0]          rounded;
  logic signed [XW-1:0] s2_exp_d;
  logic [22:0]          s2_frac_d;
  logic                 s2_inexact_d;

  always_comb begin
    round_up     = s1_mant_q[G] & (s1_mant_q[R] | s1_mant_q[S] | s1_mant_q[G+1]);
    rounded      = {1'b0, s1_mant_q[HIDDEN:G+1]} + {24'd0, round_up};
    s2_inexact_d = s1_mant_q[G] | s1_mant_q[R] | s1_mant_q[S];
    s2_exp_d     = s1_exp_q;
    s2_frac_d    = rounded[22:0];
    // A carry out of the significand can only come from all-ones, so the
    // renormalized fraction is zero.
    if (rounded[24]) begin
      s2_exp_d  = s1_exp_q + EXP_ONE;
      s2_frac_d = rounded[23:1];
    end
  end

  logic                 s2_valid_q, s2_sign_q, s2_zero_q, s2_inexact_q;
  logic signed [XW-1:0] s2_exp_q;
  logic [22:0]          s2_frac_q;
  logic [1:0]           s2_op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_zero_q    <= 1'b0;
      s2_inexact_q <= 1'b0;
      s2_exp_q     <= '0;
      s2_frac_q    <= '0;
      s2_op_q      <= '0;
    end else if (advance) begin
      s2_valid_q   <= s1_valid_q;
      s2_sign_q    <= s1_sign_q;
      s2_zero_q    <= s1_zero_q;
      s2_inexact_q <= s2_inexact_d;
      s2_exp_q     <= s2_exp_d;
      s2_frac_q    <= s2_frac_d;
      s2_op_q      <= s1_op_q;
    end
  end

  // ---------------- S3: exceptions and pack ----------------
  logic [31:0] res_d;
  fpu_flags_t  flags_d;

  always_comb begin
    res_d   = pack_sp(s2_sign_q, s2_exp_q[7:0], s2_frac_q);
    flags_d = '{overflow: 1'b0, underflow: 1'b0, inexact: s2_inexact_q};
    if (s2_zero_q) begin
      res_d   = s2_sign_q ? NEG_ZERO : POS_ZERO;
      flags_d = '0;
    end else if (s2_exp_q >= EXP_TOP) begin
      res_d   = s2_sign_q ? NEG_INF : POS_INF;
      flags_d = '{overflow: 1'b1, underflow: 1'b0, inexact: 1'b1};
    end else if (s2_exp_q <= EXP_LOW) begin
      res_d   = s2_sign_q ? NEG_ZERO : POS_ZERO;
      flags_d = '{overflow: 1'b0, underflow: 1'b1, inexact: 1'b1};
    end
  end

  logic        out_valid_q;
  logic [31:0] res_q;
  logic [1:0]  op_q;
  fpu_flags_t  flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      op_q        <= '0;
      flags_q     <= '0;
    end else if (advance) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        res_q   <= res_d;
        op_q    <= s2_op_q;
        flags_q <= flags_d;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_result    = res_q;
  assign out_operator  = op_q;
  assign out_overflow  = flags_q.overflow;
  assign out_underflow = flags_q.underflow;
  assign out_inexact   = flags_q.inexact;

endmodule

// File: tb/tb_fpu_pack.sv
// Directed bench for fpu_pack: single-beat latency vectors, backpressure with a
// full pipe, and asynchronous reset with beats in flight.
module tb_fpu_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, in_sign;
  logic [9:0]  in_exponent;
  logic [27:0] in_mantissa;
  logic [1:0]  in_operator;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [1:0]  out_operator;
  logic        out_overflow, out_underflow, out_inexact;

  int n_cmp = 0;
  int n_err = 0;

  fpu_pack #(.MANT_W(28), .EXP_W(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exponent  (in_exponent),
    .in_mantissa  (in_mantissa),
    .in_operator  (in_operator),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_operator (out_operator),
    .out_overflow (out_overflow),
    .out_underflow(out_underflow),
    .out_inexact  (out_inexact)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] flags3();
    return {29'd0, out_overflow, out_underflow, out_inexact};
  endfunction

  // Called #1 after a posedge; checks out_valid appears on the third edge.
  task automatic send_latency(input string tag, input logic s, input logic [9:0] e,
                              input logic [27:0] m, input logic [1:0] op,
                              input logic [31:0] r, input logic [2:0] f);
    out_ready   = 1'b1;
    in_sign     = s;
    in_exponent = e;
    in_mantissa = m;
    in_operator = op;
    in_valid    = 1'b1;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_lat2"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, out_result, r);
    check({tag, "_op"}, 32'(out_operator), 32'(op));
    check({tag, "_flags"}, flags3(), 32'(f));
    $display("%s: result %h op %b ovf/unf/inx %b", tag, out_result, out_operator, flags3());
    @(posedge clk); #1;
  endtask

  logic [31:0] bp_exp[5];
  int          got, last_cyc;
  logic        acc;

  initial begin
    in_valid    = 1'b0;
    in_sign     = 1'b0;
    in_exponent = '0;
    in_mantissa = '0;
    in_operator = '0;
    out_ready   = 1'b0;

    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_op", 32'(out_operator), 32'd0);
    check("rst_flags", flags3(), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_latency("one",      1'b0, 10'd127, 28'h4000000, 2'b01, 32'h3F800000, 3'b000);
    send_latency("carry",    1'b0, 10'd127, 28'h8000000, 2'b00, 32'h40000000, 3'b000);
    send_latency("lzc6",     1'b0, 10'd130, 28'h0100000, 2'b10, 32'h3E000000, 3'b000);
    send_latency("tie_even", 1'b0, 10'd127, 28'h4000004, 2'b00, 32'h3F800000, 3'b001);
    send_latency("tie_odd",  1'b0, 10'd127, 28'h400000C, 2'b01, 32'h3F800002, 3'b001);
    send_latency("carry_sticky", 1'b0, 10'd127, 28'h8000001, 2'b00, 32'h40000000, 3'b001);
    send_latency("ovf",      1'b0, 10'd254, 28'h7FFFFFC, 2'b00, 32'h7F800000, 3'b101);
    send_latency("unf",      1'b1, 10'd0,   28'h4000000, 2'b11, 32'h80000000, 3'b011);
    send_latency("neg_exp",  1'b0, 10'h3FF, 28'h4000000, 2'b00, 32'h00000000, 3'b011);
    send_latency("zero",     1'b1, 10'd50,  28'h0000000, 2'b01, 32'h80000000, 3'b000);

    // Backpressure: five back-to-back beats with the consumer stalled.
    for (int k = 0; k < 5; k++) bp_exp[k] = 32'h3F800000 + (32'(k) << 23);
    out_ready = 1'b0;
    fork
      begin : drv
        for (int k = 0; k < 5; k++) begin
          in_sign     = 1'b0;
          in_exponent = 10'(127 + k);
          in_mantissa = 28'h4000000;
          in_operator = 2'(k);
          in_valid    = 1'b1;
          acc = 1'b0;
          for (int t = 0; t < 60 && !acc; t++) begin
            @(negedge clk) acc = in_ready;
            @(posedge clk); #1;
          end
          if (!acc) check("bp_drv_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
      end
      begin : ctl
        repeat (6) @(posedge clk);
        #1;
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        check("bp_full_valid", 32'(out_valid), 32'd1);
        check("bp_hold0", out_result, bp_exp[0]);
        repeat (2) @(posedge clk);
        #1;
        check("bp_hold1", out_result, bp_exp[0]);
        check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        got = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
          @(negedge clk);
          if (out_valid) begin
            check("bp_order", out_result, bp_exp[got]);
            if (got > 0) check("bp_gap", 32'(cyc - last_cyc), 32'd1);
            $display("bp beat %0d: result %h", got, out_result);
            last_cyc = cyc;
            got++;
          end
        end
        check("bp_count", 32'(got), 32'd5);
        @(negedge clk);
        check("bp_nodup", 32'(out_valid), 32'd0);
      end
    join
    @(posedge clk); #1;

    // Reset with three beats in flight.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_sign     = 1'b1;
      in_exponent = 10'(100 + k);
      in_mantissa = 28'h4000000;
      in_operator = 2'b10;
      in_valid    = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_result", out_result, 32'd0);
    check("arst_op", 32'(out_operator), 32'd0);
    check("arst_flags", flags3(), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send_latency("post_rst", 1'b0, 10'd128, 28'h6000000, 2'b11, 32'h40400000, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
